// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: opcodes, hazard FSM state encoding, NOP word.
package rv_pipe_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

  function automatic logic is_nop(input logic [31:0] instr);
    return instr == NOP_INSTR;
  endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Source-register extraction and usage decode for the instruction held in IF/ID.
module reg_use_decode
  import rv_pipe_pkg::*;
(
  input  logic [31:0] id_instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = id_instr[6:0];
  assign rs1         = id_instr[19:15];
  assign rs2         = id_instr[24:20];
  assign unused_bits = ^{id_instr[31:25], id_instr[14:7]};

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OP, STORE, BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_IMM, LOAD, JALR: rs1_used = 1'b1;
      // Immediate-only formats read no register fields.
      LUI, AUIPC, JAL: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, memory freeze with watchdog, branch flush.
// Optional performance counters enabled by defining HAZARD_PERF_EN.
module hazard_stall_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 255,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_busy,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             timeout_err,
  output logic [1:0]       state_dbg
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used;
  logic       load_use;

  hz_state_e        state_q, state_d;
  hz_state_e        ret_q, ret_d;
  hz_state_e        eff_state;
  logic [2:0]       flush_cnt_q, flush_cnt_d, flush_nxt;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_hit;

  logic pc_w_c, ifid_w_c, ifid_f_c, idex_w_c, idex_b_c;

  reg_use_decode u_decode (
    .id_instr (id_instr),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

  // A freeze is transparent: once memory is ready the saved state is evaluated as if never left.
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    flush_cnt_d = flush_cnt_q;
    flush_nxt   = 3'd0;
    wait_cnt_d  = '0;
    timeout_hit = 1'b0;
    pc_w_c      = 1'b0;
    ifid_w_c    = 1'b0;
    ifid_f_c    = 1'b0;
    idex_w_c    = 1'b0;
    idex_b_c    = 1'b0;

    if (mem_busy) begin
      state_d = ST_MEM_WAIT;
      ret_d   = eff_state;
      if (state_q == ST_MEM_WAIT)
        wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
      else
        wait_cnt_d = CNT_W'(1);
      timeout_hit = (32'(wait_cnt_d) >= MAX_WAIT);
    end else if (branch_taken || eff_state == ST_FLUSH) begin
      pc_w_c   = 1'b1;
      ifid_w_c = 1'b1;
      ifid_f_c = 1'b1;
      idex_w_c = 1'b1;
      idex_b_c = 1'b1;
      // The count holds the flush cycles still owed after the current one.
      flush_nxt   = branch_taken ? FLUSH_RELOAD : flush_cnt_q - 1'b1;
      flush_cnt_d = flush_nxt;
      state_d     = (flush_nxt == 3'd0) ? ST_RUN : ST_FLUSH;
      ret_d       = ST_RUN;
    end else if (load_use) begin
      idex_w_c = 1'b1;
      idex_b_c = 1'b1;
      state_d  = ST_RUN;
      ret_d    = ST_RUN;
    end else begin
      pc_w_c   = 1'b1;
      ifid_w_c = 1'b1;
      idex_w_c = 1'b1;
      state_d  = ST_RUN;
      ret_d    = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      flush_cnt_q <= 3'd0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      if (timeout_hit)
        timeout_q <= 1'b1;
    end
  end

  assign pc_write    = pc_w_c   & ~rst;
  assign ifid_write  = ifid_w_c & ~rst;
  assign ifid_flush  = ifid_f_c & ~rst;
  assign idex_write  = idex_w_c & ~rst;
  assign idex_bubble = idex_b_c & ~rst;
  assign timeout_err = (timeout_q | timeout_hit) & ~rst;
  assign state_dbg   = rst ? 2'd0 : state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_w_c && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (ifid_f_c && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (FLUSH_CYCLES=2, MAX_WAIT=4).
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_busy;
  logic        branch_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic        timeout_err;
  logic [1:0]  state_dbg;
`ifdef HAZARD_PERF_EN
  logic [7:0]  stall_cycles, flush_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADD_X6_X5_X2 = 32'h00228333;
  localparam logic [31:0] LUI_X7       = 32'h000283B7;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h00000333;
  localparam logic [31:0] NOP          = 32'h00000013;

  // Output vector order: pc_write, ifid_write, ifid_flush, idex_write, idex_bubble.
  localparam logic [4:0] O_RUN   = 5'b11010;
  localparam logic [4:0] O_STALL = 5'b00011;
  localparam logic [4:0] O_FLUSH = 5'b11111;
  localparam logic [4:0] O_FRZ   = 5'b00000;

  hazard_stall_ctrl #(.FLUSH_CYCLES(2), .MAX_WAIT(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_instr     (id_instr),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .mem_busy     (mem_busy),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's Mealy outputs, state and watchdog flag.
  task automatic cyc(input string tag, input logic [4:0] o, input logic [1:0] st, input logic to);
    #2;
    chk({tag, ".outs"}, {27'd0, pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}, {27'd0, o});
    chk({tag, ".state"}, {30'd0, state_dbg}, {30'd0, st});
    chk({tag, ".timeout"}, {31'd0, timeout_err}, {31'd0, to});
    $display("step %s outs=%b state=%0d timeout=%b", tag,
             {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}, state_dbg, timeout_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_instr = NOP; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_busy = 1'b0; branch_taken = 1'b1;
    @(posedge clk); #1;
    cyc("reset", O_FRZ, 2'd0, 1'b0);
    rst = 1'b0; branch_taken = 1'b0;
    cyc("idle", O_RUN, 2'd0, 1'b0);

    ex_mem_read = 1'b1; ex_rd = 5'd5; id_instr = ADD_X6_X5_X2;
    cyc("lu_rs1", O_STALL, 2'd0, 1'b0);
    ex_mem_read = 1'b0;
    cyc("lu_after", O_RUN, 2'd0, 1'b0);
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_instr = LUI_X7;
    cyc("lui_nomatch", O_RUN, 2'd0, 1'b0);
    ex_rd = 5'd0; id_instr = ADD_X6_X0_X0;
    cyc("x0_nomatch", O_RUN, 2'd0, 1'b0);
    ex_rd = 5'd2; id_instr = ADD_X6_X5_X2;
    cyc("lu_rs2", O_STALL, 2'd0, 1'b0);

    ex_mem_read = 1'b0; branch_taken = 1'b1;
    cyc("br0", O_FLUSH, 2'd0, 1'b0);
    branch_taken = 1'b0;
    cyc("br1", O_FLUSH, 2'd2, 1'b0);
    cyc("br_done", O_RUN, 2'd0, 1'b0);

    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    cyc("br_lu0", O_FLUSH, 2'd0, 1'b0);
    branch_taken = 1'b0; ex_mem_read = 1'b0;
    cyc("br_lu1", O_FLUSH, 2'd2, 1'b0);
    cyc("br_lu_done", O_RUN, 2'd0, 1'b0);

    mem_busy = 1'b1;
    cyc("frz1", O_FRZ, 2'd0, 1'b0);
    cyc("frz2", O_FRZ, 2'd1, 1'b0);
    cyc("frz3", O_FRZ, 2'd1, 1'b0);
    cyc("frz4", O_FRZ, 2'd1, 1'b1);
    cyc("frz5", O_FRZ, 2'd1, 1'b1);
    cyc("frz6", O_FRZ, 2'd1, 1'b1);
    mem_busy = 1'b0;
    cyc("frz_end", O_RUN, 2'd1, 1'b1);
    cyc("frz_after", O_RUN, 2'd0, 1'b1);

    mem_busy = 1'b1;
    cyc("frz_rst1", O_FRZ, 2'd0, 1'b1);
    #3; rst = 1'b1;
    #1;
    chk("async_rst.timeout", {31'd0, timeout_err}, 32'd0);
    chk("async_rst.state", {30'd0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_busy = 1'b0;
    cyc("post_rst", O_RUN, 2'd0, 1'b0);

    branch_taken = 1'b1;
    cyc("fb_br", O_FLUSH, 2'd0, 1'b0);
    branch_taken = 1'b0; mem_busy = 1'b1;
    cyc("fb_frz1", O_FRZ, 2'd2, 1'b0);
    cyc("fb_frz2", O_FRZ, 2'd1, 1'b0);
    mem_busy = 1'b0;
    cyc("fb_resume", O_FLUSH, 2'd1, 1'b0);
    cyc("fb_done", O_RUN, 2'd0, 1'b0);

    mem_busy = 1'b1; branch_taken = 1'b1;
    cyc("hb_frz", O_FRZ, 2'd0, 1'b0);
    mem_busy = 1'b0;
    cyc("hb_act", O_FLUSH, 2'd1, 1'b0);
    branch_taken = 1'b0;
    cyc("hb_flush", O_FLUSH, 2'd2, 1'b0);
    cyc("hb_done", O_RUN, 2'd0, 1'b0);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_busy = 1'b1;
    cyc("pf_frz1", O_FRZ, 2'd0, 1'b0);
    cyc("pf_frz2", O_FRZ, 2'd1, 1'b0);
    cyc("pf_frz3", O_FRZ, 2'd1, 1'b0);
    mem_busy = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd5; id_instr = ADD_X6_X5_X2;
    cyc("pf_lu", O_STALL, 2'd1, 1'b0);
    ex_mem_read = 1'b0;
    cyc("pf_idle", O_RUN, 2'd0, 1'b0);
`ifdef HAZARD_PERF_EN
    chk("perf.stall_cycles", {24'd0, stall_cycles}, 32'd4);
    chk("perf.flush_cycles", {24'd0, flush_cycles}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer side of the IF/ID write-enable interface: generates `pc_write`, `ifid_write`, `ifid_flush`, `idex_write` and `idex_bubble` for the 5-stage RV32I pipeline.
- Decodes the instruction held in IF/ID to detect load-use hazards.
- Freezes the whole pipeline while data memory is busy.
- Flushes wrong-path instructions after a taken branch resolved in EX.
- Keeps a watchdog on memory stalls.

Parameters:
- FLUSH_CYCLES, 1, number of cycles IF/ID flush and ID/EX bubble are held after a taken branch (range 1..7).
- MAX_WAIT, 255, consecutive `mem_busy` cycles that set `timeout_err`.
- CNT_W, 8, width of the memory-wait and performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- id_instr  in  32  instruction currently in IF/ID
- ex_mem_read  in  1  instruction in ID/EX is a load
- ex_rd  in  5  destination register of the ID/EX instruction
- mem_busy  in  1  data memory not ready; the pipeline must freeze
- branch_taken  in  1  branch/jump in EX redirects the PC this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID load NOP instead of the fetched word
- idex_write  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX control fields zeroed
- timeout_err  out  1  sticky watchdog flag
- state_dbg  out  2  current FSM state

Behaviour:
- Reset `rst` is asynchronous and active-high; clock is `clk`.
- While `rst` is high:
  - FSM = RUN, counters = 0, `timeout_err` = 0.
  - All outputs = 0, overriding the combinational logic.
- Outputs are combinational from the registered state and the current inputs (Mealy), so a stall takes effect in the same cycle.
- Register-use decode by opcode:
  - `rs1` is used for OP (0110011), OP-IMM, LOAD, STORE, BRANCH and JALR.
  - `rs2` is used for OP, STORE and BRANCH.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
- `load_use` = `ex_mem_read` & (`ex_rd` != 0) & ((`rs1` used & `rs1` == `ex_rd`) | (`rs2` used & `rs2` == `ex_rd`)).
- FSM states: RUN=0, MEM_WAIT=1, FLUSH=2.
- RUN, priority `mem_busy` > `branch_taken` > `load_use`:
  - `mem_busy`: all write enables 0, flush/bubble 0, wait counter = 1, next state MEM_WAIT.
  - `branch_taken`: `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, `idex_write`=1, `idex_bubble`=1. Go to FLUSH with flush count = FLUSH_CYCLES-1 if FLUSH_CYCLES>1, otherwise stay in RUN. `load_use` is ignored.
  - `load_use`: `pc_write`=0, `ifid_write`=0, `idex_write`=1, `idex_bubble`=1. Single-cycle stall, stay in RUN.
  - otherwise: all writes 1, flush/bubble 0.
- MEM_WAIT:
  - All write enables 0, flush/bubble 0.
  - While `mem_busy`=1: wait counter increments and saturates at its maximum. When the count reaches MAX_WAIT, `timeout_err` is set and held until reset. The state stays MEM_WAIT.
  - When `mem_busy`=0: that cycle is evaluated exactly as RUN, including branch and load-use; next state follows the RUN rules; wait counter clears.
  - A branch held in EX during the freeze is therefore acted on after the freeze ends.
- FLUSH:
  - `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, `idex_write`=1, `idex_bubble`=1.
  - Decrement the count; return to RUN when it reaches 0.
  - `mem_busy` in FLUSH: freeze as in MEM_WAIT and resume FLUSH with the remaining count afterwards (save the return state).
  - A new `branch_taken` in FLUSH reloads the count.
- Reset mid-stall: immediate return to RUN with all counters cleared.

Optional Feature:
- Macro `HAZARD_PERF_EN`.
- When defined, adds output ports `stall_cycles` [CNT_W] and `flush_cycles` [CNT_W]: saturating counts of cycles with `pc_write`=0 and with `ifid_flush`=1. Both reset to 0.
- When undefined, these ports and their registers do not exist.

Decomposition:
- Shared package `rv_pipe_pkg`: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), FSM state encoding, NOP encoding 32'h00000013.
- One sub-module, `reg_use_decode`: combinational; `id_instr` → `rs1`, `rs2`, `rs1_used`, `rs2_used`.

Test Plan:
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_instr`=32'h00228333 (add x6,x5,x2) → one cycle of `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; the following cycle with `ex_mem_read`=0 → all writes 1.
- False match: `ex_rd`=5, `id_instr`=32'h000283B7 (lui x7, rs1 field=5) → no stall. `ex_rd`=0 with a matching x0 source → no stall.
- Branch with FLUSH_CYCLES=2: `branch_taken` for 1 cycle → `ifid_flush`=1 and `idex_bubble`=1 for exactly 2 cycles; `state_dbg` 0→2→0.
- Branch and load-use in the same cycle → flush response only, `pc_write`=1.
- Memory freeze with MAX_WAIT=4: `mem_busy` held 6 cycles → all enables 0 for 6 cycles, `timeout_err` rises on the 4th and stays 1 after `mem_busy` drops. `rst` pulse mid-freeze → `timeout_err`=0, state RUN.
- `HAZARD_PERF_EN`: a 3-cycle freeze plus one load-use stall → `stall_cycles`=4.
